// File: rtl/synapse_mac.sv
// synapse_mac: time-multiplexed NC-neuron multiply-accumulate over an NP-element input vector.
// One input element per cycle, all accumulators updated in parallel, valid/ready on both sides.
module synapse_mac #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WD = 4,
    localparam int SW = $clog2(NP) + 1 + WD,
    localparam int AW = $clog2(NP * NC)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid_AS,
    output logic              oReady_AS,
    input  logic [NP*WD-1:0]  iData_AS,
    output logic              oValid_BS,
    input  logic              iReady_BS,
    output logic [NC*SW-1:0]  oData_BS,
    input  logic              iWe,
    input  logic [AW-1:0]     iWaddr,
    input  logic [WD-1:0]     iWdata
);
    localparam int FRAC = WD - 1;
    localparam int KW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state, state_nxt;
    logic signed [WD-1:0]  x [NP];
    logic signed [WD-1:0]  w [NP*NC];
    logic signed [SW-1:0]  acc [NC];
    logic signed [SW-1:0]  acc_nxt [NC];
    logic signed [2*WD-1:0] prod [NC];
    logic [KW-1:0]         k;
    logic [NC*SW-1:0]      sums;
    logic                  accept, last;

    assign oReady_AS = (state == IDLE) || (state == DONE && iReady_BS);
    assign oValid_BS = state == DONE;
    assign oData_BS  = sums;
    assign accept    = iValid_AS && oReady_AS;
    assign last      = k == KW'(NP - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = iValid_AS ? ACC : IDLE;
            ACC:     state_nxt = last ? DONE : ACC;
            DONE:    state_nxt = iReady_BS ? (iValid_AS ? ACC : IDLE) : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // The shifted product keeps the top WD+1 bits of the full product: floor toward -inf.
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            prod[c]    = (2*WD)'(x[k]) * (2*WD)'(w[c*NP + int'(k)]);
            acc_nxt[c] = acc[c] + SW'($signed(prod[c][2*WD-1:FRAC]));
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            k     <= '0;
            sums  <= '0;
            for (int p = 0; p < NP; p++) x[p] <= '0;
            for (int c = 0; c < NC; c++) acc[c] <= '0;
            for (int a = 0; a < NP*NC; a++) w[a] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                for (int p = 0; p < NP; p++) x[p] <= iData_AS[p*WD +: WD];
                for (int c = 0; c < NC; c++) acc[c] <= '0;
                k <= '0;
            end else if (state == ACC) begin
                for (int c = 0; c < NC; c++) acc[c] <= acc_nxt[c];
                k <= k + KW'(1);
                if (last)
                    for (int c = 0; c < NC; c++) sums[c*SW +: SW] <= acc_nxt[c];
            end
            if (iWe && int'(iWaddr) < NP*NC)
                w[iWaddr] <= iWdata;
        end
    end
endmodule

// File: tb/tb_synapse_mac.sv
// tb_synapse_mac: randomized and directed scoreboard bench for synapse_mac.
module tb_synapse_mac;
    localparam int NP = 4, NC = 4, WD = 4;
    localparam int SW = $clog2(NP) + 1 + WD, AW = $clog2(NP * NC), FRAC = WD - 1;

    logic iCLK = 0, iRST = 1, iValid_AS = 0, iReady_BS = 1, iWe = 0;
    logic oReady_AS, oValid_BS;
    logic [NP*WD-1:0] iData_AS = '0;
    logic [NC*SW-1:0] oData_BS;
    logic [AW-1:0] iWaddr = '0;
    logic [WD-1:0] iWdata = '0;

    int checks = 0, failures = 0;
    int mw [NP*NC];
    logic [NC*SW-1:0] sb [$];
    bit rnd = 0;

    always #5 iCLK = ~iCLK;

    synapse_mac #(.NP(NP), .NC(NC), .WD(WD)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid_AS(iValid_AS), .oReady_AS(oReady_AS),
        .iData_AS(iData_AS), .oValid_BS(oValid_BS), .iReady_BS(iReady_BS),
        .oData_BS(oData_BS), .iWe(iWe), .iWaddr(iWaddr), .iWdata(iWdata)
    );

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: each sum is the plain sum of floor(x*w / 2^FRAC) over the vector.
    function automatic logic [NC*SW-1:0] model(int v [NP]);
        logic [NC*SW-1:0] r;
        int s;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int p = 0; p < NP; p++) s += (v[p] * mw[c*NP + p]) >>> FRAC;
            r[c*SW +: SW] = s[SW-1:0];
        end
        return r;
    endfunction

    task automatic write_w(int a, int d);
        iWe = 1;
        iWaddr = AW'(a);
        iWdata = WD'(d);
        tick;
        iWe = 0;
        mw[a] = d;
    endtask

    task automatic set_all(int d);
        for (int a = 0; a < NP*NC; a++) write_w(a, d);
    endtask

    task automatic set_vec(int v [NP]);
        for (int p = 0; p < NP; p++) iData_AS[p*WD +: WD] = WD'(v[p]);
    endtask

    task automatic send(int v [NP]);
        bit ok;
        ok = 0;
        set_vec(v);
        iValid_AS = 1;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (rnd) iReady_BS = ($urandom_range(0, 3) != 0);
            #1;
            ok = oReady_AS;
            if (!ok) tick;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
        end else begin
            sb.push_back(model(v));
            tick;
        end
        iValid_AS = 0;
    endtask

    task automatic latency;
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (!oValid_BS && n < 20);
        check("latency", 64'(n), 64'(NP));
    endtask

    task automatic drain;
        int n;
        n = 0;
        iReady_BS = 1;
        while ((sb.size() != 0 || oValid_BS) && n < 50) begin
            tick;
            n++;
        end
        check("drain", 64'(n < 50), 64'(1));
    endtask

    always @(negedge iCLK) begin
        if (!iRST && oValid_BS && iReady_BS) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%0h exp=none", oData_BS);
            end else check("sums", 64'(oData_BS), 64'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v [NP], b [NP];
        logic [NC*SW-1:0] held;
        for (int a = 0; a < NP*NC; a++) mw[a] = 0;
        repeat (3) tick;
        iRST = 0;
        check("rst_valid", 64'(oValid_BS), 0);
        check("rst_ready", 64'(oReady_AS), 1);
        check("rst_data", 64'(oData_BS), 0);

        set_all(4);
        v = '{default: 4};
        send(v);
        latency;
        drain;

        set_all(-8);
        v = '{default: -8};
        send(v);
        drain;
        v = '{default: 7};
        send(v);
        drain;
        set_all(-1);
        v = '{default: 1};
        send(v);
        drain;

        for (int a = 0; a < NP*NC; a++) write_w(a, a / NP + 1);
        v = '{7, 0, 0, 0};
        send(v);
        drain;

        set_all(2);
        iReady_BS = 0;
        v = '{3, -5, 7, 1};
        send(v);
        latency;
        held = oData_BS;
        b = '{-8, 7, 6, -2};
        set_vec(b);
        iValid_AS = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            check("bp_data", 64'(oData_BS), 64'(held));
            check("bp_ready", 64'(oReady_AS), 0);
        end
        tick;
        sb.push_back(model(b));
        iReady_BS = 1;
        #1;
        check("bp_same_cycle_ready", 64'(oReady_AS), 1);
        tick;
        iValid_AS = 0;
        latency;
        drain;

        set_all(3);
        v = '{default: 7};
        send(v);
        tick;
        tick;
        iRST = 1;
        tick;
        iRST = 0;
        sb.delete();
        for (int a = 0; a < NP*NC; a++) mw[a] = 0;
        check("midacc_rst_valid", 64'(oValid_BS), 0);
        check("midacc_rst_ready", 64'(oReady_AS), 1);
        send(v);
        drain;

        set_all(2);
        send(v);
        tick;
        iWe = 1;
        iWaddr = AW'(1);
        iWdata = WD'(-8);
        tick;
        iWe = 0;
        mw[1] = -8;
        drain;
        send(v);
        drain;

        for (int blk = 0; blk < 4; blk++) begin
            rnd = 0;
            drain;
            for (int a = 0; a < NP*NC; a++) write_w(a, int'($urandom_range(0, 15)) - 8);
            rnd = 1;
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    iReady_BS = ($urandom_range(0, 3) != 0);
                    tick;
                end
                for (int p = 0; p < NP; p++) v[p] = int'($urandom_range(0, 15)) - 8;
                send(v);
            end
        end
        rnd = 0;
        drain;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/synapse_mac.md
# synapse_mac

Time-multiplexed multiply-accumulate stage that sits directly upstream of the neuron activation stage. It accepts one activation vector of NP signed WD-bit values and multiplies it against an internal NC×NP signed weight array. It produces NC signed pre-activation sums of width $clog2(NP)+1+WD, packed exactly as the activation stage consumes them. It processes one input element per cycle, updates all NC accumulators in parallel, and uses valid/ready handshakes on both sides.

## Interface
- NP, 4, number of inputs per neuron (previous-layer width); NP*NC ≥ 2
- NC, 4, number of neurons (accumulators) in this layer
- WD, 4, data/weight width; signed fixed point with FRAC = WD-1 fractional bits
- Derived SW = $clog2(NP)+1+WD (sum width), AW = $clog2(NP*NC) (weight address width)
- iCLK  in  1  clock
- iRST  in  1  reset, synchronous, active-high; clock iCLK
- iValid_AS  in  1  input vector valid
- oReady_AS  out  1  input vector accepted when high with iValid_AS
- iData_AS  in  NP*WD  element p at bits [p*WD +: WD]
- oValid_BS  out  1  sums valid
- iReady_BS  in  1  downstream accepts sums
- oData_BS  out  NC*SW  sum c at bits [c*SW +: SW]
- iWe  in  1  weight write enable
- iWaddr  in  AW  weight index = c*NP + p
- iWdata  in  WD  signed weight value

## Operation
- The block has three states: IDLE, ACC, DONE.
- IDLE: oReady_AS=1, oValid_BS=0. On iValid_AS:
  - latch iData_AS into the input register;
  - clear all accumulators;
  - set counter k=0;
  - go to ACC.
- ACC: oReady_AS=0, oValid_BS=0. Each cycle, for every c: acc[c] += (x[k] * w[c*NP+k]) >>> FRAC.
  - The product is the full 2*WD signed product. The arithmetic shift floors toward −∞, giving a WD+1-bit value.
  - The counter k increments each cycle. After the k=NP-1 update, go to DONE.
- DONE: oValid_BS=1, oData_BS = acc[]. The sums are held stable until iReady_BS.
  - oReady_AS = iReady_BS, so a new vector can be accepted in the same cycle the sums are consumed.
  - iReady_BS=1 and iValid_AS=1: sums consumed, new vector latched, accumulators cleared, k=0, go to ACC.
  - iReady_BS=1 and iValid_AS=0: go to IDLE.
  - iReady_BS=0: stay in DONE; oValid_BS and oData_BS do not change.
- Width rules:
  - Each shifted product lies in [−2^(WD-1), 2^(WD-1)], which fits WD+1 bits signed.
  - NP such terms fit SW bits exactly; no saturation is needed and overflow is impossible.
  - The accumulators are SW bits, sign-extended.
- Weights:
  - The weight array is NC*NP registers of WD bits, written by iWe/iWaddr/iWdata in any state.
  - A write takes effect from the next cycle; an ACC read in the same cycle sees the old value.
  - iWaddr ≥ NP*NC is ignored.
  - Weights are not part of the data handshake. Software must load them before streaming vectors for deterministic results.
- Reset (any state, including mid-ACC or DONE):
  - state=IDLE, k=0, accumulators=0, input register=0, oValid_BS=0, oData_BS=0.
  - oReady_AS=1 from the first cycle after reset.
  - The weight array is also cleared to 0.
  - A partially accumulated vector is discarded and never emitted.

## Timing
- Acceptance at rising edge E0 (iValid_AS & oReady_AS). ACC occupies edges E1..E(NP). oValid_BS rises after edge E(NP), i.e. NP cycles after acceptance.
- Throughput is one vector per NP+1 cycles with continuous iReady_BS.
- oReady_AS is combinational from state and iReady_BS. No combinational path exists from iValid_AS to any output.
- iData_AS is sampled only at the acceptance edge; it may change freely afterward.
- oData_BS is registered; it changes only on entry to DONE and is held there.

## Test plan
- Basic sums (NP=NC=WD=4):
  - Stimulus: all weights 4 (0.5), vector {4,4,4,4}.
  - Required: each sum is 8 (0x08 in 7 bits); oValid_BS rises 4 cycles after acceptance.
- Extremes:
  - Stimulus: all weights −8, inputs all −8.
  - Required: each sum +32.
  - Stimulus: inputs 7, weights −8.
  - Required: each sum −28.
  - Stimulus: input 1, weight −1.
  - Required: each term −1, sum −4 (floor rounding).
- Distinct neurons:
  - Stimulus: w[c*4+p] = c+1, inputs {7,0,0,0}.
  - Required: sums {0,1,2,3} (7*(c+1) >>> 3).
- Backpressure:
  - Stimulus: hold iReady_BS=0 for 10 cycles in DONE while iValid_AS=1.
  - Required: oData_BS stable, oReady_AS=0, no acceptance.
  - Stimulus: raise iReady_BS.
  - Required: consume and accept the new vector in the same cycle; the next result follows NP cycles later.
- Reset mid-ACC:
  - Stimulus: assert iRST at k=2.
  - Required: next cycle oValid_BS=0, oReady_AS=1; weights read 0; the following vector yields sums 0.
- Weight write during ACC:
  - Stimulus: write w[1] at the cycle k=1 is read.
  - Required: the current result uses the old value; the next vector uses the new value.
